// File: rtl/core_mem_responder_pkg.sv
// Shared definitions for the core memory responder: NOP encoding, FSM states,
// and the fetch-output source selector.
package core_mem_responder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Source of the registered instruction word presented to the core
  typedef enum logic [1:0] {
    IF_NOP  = 2'd0,
    IF_ZERO = 2'd1,
    IF_MEM  = 2'd2
  } if_sel_t;

endpackage

// File: rtl/core_mem_responder_mem_word_array.sv
// DEPTH x DATA_WIDTH word storage: one write port, one combinational read port
// for data/host accesses and one registered read port for instruction fetch.
module mem_word_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [IDX_W-1:0]      if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // Fetch port samples the pre-write word when a write hits the same index
  always_ff @(posedge clk) begin
    if_rdata <= mem[if_addr];
  end

endmodule

// File: rtl/core_mem_responder.sv
// Unified IMEM/DMEM scratchpad beside the core. A LOAD/RUN FSM keeps the core
// in reset while the host loads the RAM, then releases it and counts RUN cycles.
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           i_pc_IF,
  output logic [DATA_WIDTH-1:0] o_instr_ID,
  input  logic                  i_mem_write_M,
  input  logic [31:0]           i_data_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_core_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_host_valid,
  output logic                  o_host_ready,
  input  logic                  i_host_we,
  input  logic [31:0]           i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_host_rvalid,
  output logic                  o_running,
  output logic                  o_err,
  output logic [31:0]           o_cycle_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (IDX_W + 2)) == 32'd0;
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    return !in_range(a) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  state_t                state;
  if_sel_t               if_sel;
  logic                  run;
  logic                  host_xfer;
  logic                  host_rd;
  logic                  err_set;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] if_word;

  assign run          = (state == ST_RUN);
  assign o_running    = run;
  assign o_host_ready = (state == ST_LOAD);
  assign host_xfer    = i_host_valid && o_host_ready;
  assign host_rd      = host_xfer && !i_host_we;

  // Core ports are only checked while the core is actually running
  assign err_set = (host_xfer && addr_bad(i_host_addr)) ||
                   (run && (addr_bad(i_pc_IF) || addr_bad(i_data_addr_M)));

  // Write/read port ownership follows the FSM, so host and core never collide
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx(i_host_addr);
    wr_data = i_host_wdata;
    rd_idx  = word_idx(i_host_addr);
    if (run) begin
      wr_en   = i_mem_write_M && in_range(i_data_addr_M);
      wr_idx  = word_idx(i_data_addr_M);
      wr_data = i_write_data_M;
      rd_idx  = word_idx(i_data_addr_M);
    end else begin
      wr_en   = host_xfer && i_host_we && in_range(i_host_addr);
    end
  end

  mem_word_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk      (clk),
    .we       (wr_en),
    .waddr    (wr_idx),
    .wdata    (wr_data),
    .raddr    (rd_idx),
    .rdata    (rd_word),
    .if_addr  (word_idx(i_pc_IF)),
    .if_rdata (if_word)
  );

  assign o_read_data_M = (run && in_range(i_data_addr_M)) ? rd_word : '0;

  // LOAD/RUN sequencing, registered core reset and RUN-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      o_core_rst  <= 1'b1;
      o_cycle_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (i_start && !i_stop) begin
            state       <= ST_RUN;
            o_core_rst  <= 1'b0;
            o_cycle_cnt <= '0;
          end
        end
        ST_RUN: begin
          o_cycle_cnt <= o_cycle_cnt + 32'd1;
          if (i_stop) begin
            state      <= ST_LOAD;
            o_core_rst <= 1'b1;
          end
        end
        default: begin
          state      <= ST_LOAD;
          o_core_rst <= 1'b1;
        end
      endcase
    end
  end

  // The fetch word itself comes unreset from the RAM; a reset selector makes
  // the visible instruction register come up as NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 if_sel <= IF_NOP;
    else if (!run)              if_sel <= IF_NOP;
    else if (in_range(i_pc_IF)) if_sel <= IF_MEM;
    else                        if_sel <= IF_ZERO;
  end

  // Instruction output selected from the registered fetch source
  always_comb begin
    o_instr_ID = DATA_WIDTH'(NOP_INSTR);
    case (if_sel)
      IF_MEM:  o_instr_ID = if_word;
      IF_ZERO: o_instr_ID = '0;
      default: o_instr_ID = DATA_WIDTH'(NOP_INSTR);
    endcase
  end

  // Host read pipe: data registered, rvalid pulses the cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_host_rvalid <= 1'b0;
      o_host_rdata  <= '0;
    end else begin
      o_host_rvalid <= host_rd;
      if (host_rd) o_host_rdata <= in_range(i_host_addr) ? rd_word : '0;
    end
  end

  // Sticky access error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_err <= 1'b0;
    else if (err_set) o_err <= 1'b1;
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_core_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pc_IF = '0;
  logic [31:0] o_instr_ID;
  logic        i_mem_write_M = 1'b0;
  logic [31:0] i_data_addr_M = '0;
  logic [31:0] i_write_data_M = '0;
  logic [31:0] o_read_data_M;
  logic        o_core_rst;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_host_valid = 1'b0;
  logic        o_host_ready;
  logic        i_host_we = 1'b0;
  logic [31:0] i_host_addr = '0;
  logic [31:0] i_host_wdata = '0;
  logic [31:0] o_host_rdata;
  logic        o_host_rvalid;
  logic        o_running;
  logic        o_err;
  logic [31:0] o_cycle_cnt;

  core_mem_responder #(
    .DATA_WIDTH (32),
    .DEPTH      (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pc_IF        (i_pc_IF),
    .o_instr_ID     (o_instr_ID),
    .i_mem_write_M  (i_mem_write_M),
    .i_data_addr_M  (i_data_addr_M),
    .i_write_data_M (i_write_data_M),
    .o_read_data_M  (o_read_data_M),
    .o_core_rst     (o_core_rst),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_host_valid   (i_host_valid),
    .o_host_ready   (o_host_ready),
    .i_host_we      (i_host_we),
    .i_host_addr    (i_host_addr),
    .i_host_wdata   (i_host_wdata),
    .o_host_rdata   (o_host_rdata),
    .o_host_rvalid  (o_host_rvalid),
    .o_running      (o_running),
    .o_err          (o_err),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  always #5 clk = ~clk;

  int unsigned tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  typedef enum {K_INSTR, K_RDATA, K_ERR, K_CNT, K_CORE_RST, K_RUNNING, K_READY} kind_t;
  typedef struct { kind_t kind; logic [31:0] exp; string name; } probe_t;
  typedef struct { logic [31:0] exp; int unsigned cyc; string name; } hexp_t;

  probe_t probes[$];
  hexp_t  host_q[$];
  int     total = 0;
  int     bad = 0;

  function automatic logic [31:0] sample(input kind_t k);
    case (k)
      K_INSTR:    return o_instr_ID;
      K_RDATA:    return o_read_data_M;
      K_ERR:      return {31'b0, o_err};
      K_CNT:      return o_cycle_cnt;
      K_CORE_RST: return {31'b0, o_core_rst};
      K_RUNNING:  return {31'b0, o_running};
      K_READY:    return {31'b0, o_host_ready};
      default:    return '0;
    endcase
  endfunction

  // Monitor: level probes are checked at the negedge of the cycle they were
  // posted in; every rvalid pulse must match the oldest queued host read
  initial begin
    probe_t      p;
    hexp_t       h;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (probes.size() > 0) begin
        p   = probes.pop_front();
        act = sample(p.kind);
        total++;
        if (act !== p.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", p.name, act, p.exp);
        end
      end
      if (o_host_rvalid === 1'b1) begin
        total++;
        if (host_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got rdata %h want no response", o_host_rdata);
        end else begin
          h = host_q.pop_front();
          if (o_host_rdata !== h.exp || tb_cyc != h.cyc) begin
            bad++;
            $display("FAIL %s: got rdata %h at cycle %0d want %h at cycle %0d",
                     h.name, o_host_rdata, tb_cyc, h.exp, h.cyc);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_sig(input kind_t k, input logic [31:0] e, input string n);
    probe_t p;
    p.kind = k;
    p.exp  = e;
    p.name = n;
    probes.push_back(p);
  endtask

  task automatic push_host(input logic [31:0] e, input string n);
    hexp_t h;
    h.exp  = e;
    h.cyc  = tb_cyc + 1;
    h.name = n;
    host_q.push_back(h);
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    i_host_valid = 1'b1;
    i_host_we    = 1'b1;
    i_host_addr  = a;
    i_host_wdata = d;
    cyc();
    i_host_valid = 1'b0;
    i_host_we    = 1'b0;
  endtask

  task automatic host_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    i_host_valid = 1'b1;
    i_host_we    = 1'b0;
    i_host_addr  = a;
    push_host(e, n);
    cyc();
    i_host_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    expect_sig(K_CORE_RST, 32'd1, "rst_core_rst");
    expect_sig(K_INSTR, 32'h0000_0013, "rst_instr_nop");
    expect_sig(K_READY, 32'd1, "rst_host_ready");
    expect_sig(K_ERR, 32'd0, "rst_err");
    expect_sig(K_CNT, 32'd0, "rst_cycle_cnt");
    expect_sig(K_RUNNING, 32'd0, "rst_running");
    cyc();
    cyc();
    rst_n = 1'b1;

    // Host load and readback, then start with a read on the transition edge
    host_wr(32'h4, 32'hDEAD_BEEF);
    host_wr(32'h10, 32'hAAAA_0000);
    host_wr(32'h0, 32'h0000_0111);
    host_rd(32'h4, 32'hDEAD_BEEF, "host_rd_4");
    i_pc_IF       = 32'h4;
    i_data_addr_M = 32'h0;
    i_start       = 1'b1;
    i_host_valid  = 1'b1;
    i_host_addr   = 32'h10;
    push_host(32'hAAAA_0000, "host_rd_on_start");
    cyc();
    i_start      = 1'b0;
    i_host_valid = 1'b0;
    expect_sig(K_INSTR, 32'h0000_0013, "instr_first_run_nop");
    expect_sig(K_CORE_RST, 32'd0, "run_core_rst");
    expect_sig(K_RUNNING, 32'd1, "run_running");
    expect_sig(K_READY, 32'd0, "run_host_ready");
    cyc();
    expect_sig(K_INSTR, 32'hDEAD_BEEF, "instr_fetch_4");

    // Core write: same-cycle read and fetch see the old word
    i_data_addr_M  = 32'h10;
    i_mem_write_M  = 1'b1;
    i_write_data_M = 32'h0000_1234;
    i_pc_IF        = 32'h10;
    expect_sig(K_RDATA, 32'hAAAA_0000, "rd_same_cycle_old");
    cyc();
    i_mem_write_M = 1'b0;
    expect_sig(K_RDATA, 32'h0000_1234, "rd_after_write");
    expect_sig(K_INSTR, 32'hAAAA_0000, "fetch_same_cycle_old");
    cyc();
    expect_sig(K_INSTR, 32'h0000_1234, "fetch_after_write");
    expect_sig(K_ERR, 32'd0, "err_clean_run");

    // Out-of-range and misaligned core accesses
    i_data_addr_M = 32'h400;
    expect_sig(K_RDATA, 32'd0, "oob_read_zero");
    cyc();
    expect_sig(K_ERR, 32'd1, "oob_err_set");
    i_mem_write_M  = 1'b1;
    i_write_data_M = 32'h0000_0BAD;
    cyc();
    i_mem_write_M = 1'b0;
    i_data_addr_M = 32'h0;
    expect_sig(K_RDATA, 32'h0000_0111, "oob_write_dropped");
    cyc();
    i_data_addr_M = 32'h6;
    expect_sig(K_RDATA, 32'hDEAD_BEEF, "misaligned_word1");
    cyc();
    i_data_addr_M = 32'h0;
    i_pc_IF       = 32'h4;
    expect_sig(K_ERR, 32'd1, "err_sticky");

    // Cycle counter over a 10-clock RUN window
    i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
    expect_sig(K_RUNNING, 32'd0, "stop_to_load");
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    expect_sig(K_CNT, 32'd0, "cnt_cleared_on_start");
    repeat (9) cyc();
    i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
    expect_sig(K_CNT, 32'd10, "cnt_ten");
    expect_sig(K_CORE_RST, 32'd1, "stop_core_rst");
    repeat (3) cyc();
    expect_sig(K_CNT, 32'd10, "cnt_holds_in_load");
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    expect_sig(K_CNT, 32'd0, "cnt_restart");
    cyc();
    expect_sig(K_CNT, 32'd1, "cnt_one");
    i_stop = 1'b1;
    cyc();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    i_stop  = 1'b0;
    expect_sig(K_RUNNING, 32'd0, "start_stop_stays_load");
    expect_sig(K_CORE_RST, 32'd1, "start_stop_core_rst");

    // rst_n mid-RUN with a host read in flight
    i_start      = 1'b1;
    i_host_valid = 1'b1;
    i_host_we    = 1'b0;
    i_host_addr  = 32'h4;
    cyc();
    i_start      = 1'b0;
    i_host_valid = 1'b0;
    #1 rst_n = 1'b0;
    expect_sig(K_CORE_RST, 32'd1, "midrun_rst_core_rst");
    expect_sig(K_RUNNING, 32'd0, "midrun_rst_load");
    expect_sig(K_INSTR, 32'h0000_0013, "midrun_rst_instr");
    expect_sig(K_ERR, 32'd0, "midrun_rst_err");
    expect_sig(K_CNT, 32'd0, "midrun_rst_cnt");
    cyc();
    rst_n = 1'b1;
    host_rd(32'h4, 32'hDEAD_BEEF, "host_rd_after_reset");
    expect_sig(K_ERR, 32'd0, "err_clean_host");
    host_rd(32'h6, 32'hDEAD_BEEF, "host_rd_misaligned");
    expect_sig(K_ERR, 32'd1, "host_misaligned_err");
    host_rd(32'h400, 32'd0, "host_rd_oob");
    host_rd(32'h10, 32'h0000_1234, "host_rd_core_written");

    repeat (3) cyc();
    total++;
    if (host_q.size() != 0) begin
      bad++;
      $display("FAIL host_rvalid_missing: got %0d outstanding reads want 0", host_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
